// File: rtl/gpu_rect_fetch.sv
// Scans the rectangle table in GPU memory once per start pulse and streams every
// enabled rectangle covering the latched scanline, in record order, over valid/ready.
module gpu_rect_fetch #(
    parameter int unsigned RECT_COUNT = 64,
    parameter logic [15:0] RECT_BASE  = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] line_y,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic        rect_valid,
    input  logic        rect_ready,
    output logic [15:0] rect_x,
    output logic [15:0] rect_w,
    output logic [15:0] rect_color,
    output logic [7:0]  rect_index,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_CHECK,
        S_EMIT
    } state_t;

    localparam logic [7:0] LAST_INDEX = 8'(RECT_COUNT - 1);

    state_t      state;
    logic [15:0] ptr;
    logic [15:0] scan_y;
    logic [2:0]  word;
    logic [7:0]  index;

    logic        rec_en;
    logic [15:0] rec_x;
    logic [15:0] rec_y;
    logic [15:0] rec_w;
    logic [15:0] rec_h;
    logic [15:0] rec_c;

    logic [16:0] y_end;
    logic        hit;
    logic        is_last;
    logic        advance;
    logic [15:0] next_ptr;
    logic [15:0] fetch_addr;

    // The bottom edge is formed at 17 bits so rectangles near 0xFFFF never wrap.
    assign y_end      = {1'b0, rec_y} + {1'b0, rec_h};
    assign hit        = rec_en && (rec_w != 16'd0) && (rec_y <= scan_y)
                        && ({1'b0, scan_y} < y_end);
    assign is_last    = (index == LAST_INDEX);
    assign advance    = ((state == S_CHECK) && !hit) || ((state == S_EMIT) && rect_ready);
    assign next_ptr   = ptr + 16'd6;
    assign fetch_addr = ptr + {13'd0, word} + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= 16'd0;
            scan_y     <= 16'd0;
            word       <= 3'd0;
            index      <= 8'd0;
            rec_en     <= 1'b0;
            rec_x      <= 16'd0;
            rec_y      <= 16'd0;
            rec_w      <= 16'd0;
            rec_h      <= 16'd0;
            rec_c      <= 16'd0;
            mem_addr   <= 16'd0;
            rect_valid <= 1'b0;
            rect_x     <= 16'd0;
            rect_w     <= 16'd0;
            rect_color <= 16'd0;
            rect_index <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start coinciding with the done pulse belongs to the old pass.
                    if (start && !done) begin
                        scan_y   <= line_y;
                        ptr      <= RECT_BASE;
                        index    <= 8'd0;
                        word     <= 3'd0;
                        mem_addr <= RECT_BASE;
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Read data lags the address by one cycle, so word k lands word k-1.
                    case (word)
                        3'd1:    rec_en <= mem_rdata[0];
                        3'd2:    rec_x  <= mem_rdata;
                        3'd3:    rec_y  <= mem_rdata;
                        3'd4:    rec_w  <= mem_rdata;
                        3'd5:    rec_h  <= mem_rdata;
                        default: ;
                    endcase
                    if (word == 3'd5) begin
                        state <= S_LAST;
                    end else begin
                        word     <= word + 3'd1;
                        mem_addr <= fetch_addr;
                    end
                end
                S_LAST: begin
                    rec_c <= mem_rdata;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (hit) begin
                        rect_valid <= 1'b1;
                        rect_x     <= rec_x;
                        rect_w     <= rec_w;
                        rect_color <= rec_c;
                        rect_index <= index;
                        state      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (rect_ready) begin
                        rect_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (advance) begin
                if (is_last) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    index    <= index + 8'd1;
                    ptr      <= next_ptr;
                    word     <= 3'd0;
                    mem_addr <= next_ptr;
                    state    <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_rect_fetch.sv
// Bench for gpu_rect_fetch: synchronous-read memory model, stream monitor and a
// record-list reference model computed directly from the hit rule.
module tb_gpu_rect_fetch;

    localparam int          N    = 64;
    localparam logic [15:0] BASE = 16'd40;

    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] x;
        logic [15:0] w;
        logic [15:0] c;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] line_y;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        rect_valid;
    logic        rect_ready;
    logic [15:0] rect_x;
    logic [15:0] rect_w;
    logic [15:0] rect_color;
    logic [7:0]  rect_index;
    logic        busy;
    logic        done;

    int tests    = 0;
    int failures = 0;

    gpu_rect_fetch #(.RECT_COUNT(N), .RECT_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .line_y(line_y),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rect_valid(rect_valid), .rect_ready(rect_ready),
        .rect_x(rect_x), .rect_w(rect_w), .rect_color(rect_color),
        .rect_index(rect_index), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // GPU memory: 1024x16 with a registered read port
    logic [15:0] mem [1024];
    always @(posedge clk) mem_rdata <= mem[mem_addr[9:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor, sampling half a cycle after the active edge
    int   c0;
    rec_t got[$];
    rec_t exp_q[$];
    int   valid_cycles, done_count, done_cyc, busy_count, first_busy, last_busy, stall_err;
    logic prev_stall = 1'b0;
    rec_t prev_rec, cur;

    always @(negedge clk) begin
        #1;
        cur = {rect_index, rect_x, rect_w, rect_color};
        if (!reset) begin
            if (prev_stall && !rect_valid) stall_err++;
            if (rect_valid) begin
                valid_cycles++;
                if (prev_stall && cur != prev_rec) stall_err++;
                if (rect_ready) got.push_back(cur);
            end
            prev_stall = rect_valid && !rect_ready;
            prev_rec   = cur;
            if (done) begin
                done_count++;
                done_cyc = cyc - c0;
            end
            if (busy) begin
                busy_count++;
                if (first_busy < 0) first_busy = cyc - c0;
                last_busy = cyc - c0;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Ready driver: 0 always ready, 1 random, 2 stall index 3, other never ready
    int ready_mode = 0;
    int stall_left = 0;
    always @(negedge clk) begin
        case (ready_mode)
            0: rect_ready = 1'b1;
            1: rect_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (rect_valid && rect_index == 8'd3 && stall_left > 0) begin
                    rect_ready = 1'b0;
                    stall_left--;
                end else begin
                    rect_ready = 1'b1;
                end
            end
            default: rect_ready = 1'b0;
        endcase
    end

    task automatic clear_mon();
        got.delete();
        valid_cycles = 0; done_count = 0; done_cyc = -1;
        busy_count = 0; first_busy = -1; last_busy = -1; stall_err = 0;
    endtask

    task automatic start_pass(input logic [15:0] ly);
        @(negedge clk);
        line_y = ly;
        start  = 1'b1;
        c0     = cyc;
        clear_mon();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 0;
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge clk);
            #2;
            if (done_count > 0) seen = 1;
        end
        tests++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles", bound);
        end
    endtask

    // Reference model: the list of records a pass over the current memory must emit
    task automatic build_expected(input logic [15:0] ly);
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            int a = int'(BASE) + 6 * i;
            int y = int'(mem[a + 2]);
            int h = int'(mem[a + 4]);
            if (mem[a][0] && mem[a + 3] != 16'd0 && y <= int'(ly) && int'(ly) < y + h)
                exp_q.push_back({8'(i), mem[a + 1], mem[a + 3], mem[a + 5]});
        end
    endtask

    task automatic load_tower();
        for (int i = 0; i < N; i++) begin
            int a = int'(BASE) + 6 * i;
            mem[a]     = 16'h0001;
            mem[a + 1] = 16'd0;
            mem[a + 2] = 16'd0;
            mem[a + 3] = 16'(256 - 4 * i);
            mem[a + 4] = 16'd256;
            mem[a + 5] = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; line_y = 16'd0; ready_mode = 0;
        repeat (2) @(negedge clk);
        #2;
        tests += 8;
        if (mem_addr !== 16'd0) begin failures++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
        if (rect_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", rect_valid); end
        if (rect_x !== 16'd0) begin failures++; $display("[TB] FAIL reset_x: got %h want 0", rect_x); end
        if (rect_w !== 16'd0) begin failures++; $display("[TB] FAIL reset_w: got %h want 0", rect_w); end
        if (rect_color !== 16'd0) begin failures++; $display("[TB] FAIL reset_color: got %h want 0", rect_color); end
        if (rect_index !== 8'd0) begin failures++; $display("[TB] FAIL reset_index: got %h want 0", rect_index); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        tests += 2;
        if (mem_addr !== 16'd0) begin failures++; $display("[TB] FAIL idle_mem_addr: got %h want 0", mem_addr); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_tower();
        load_tower();
        ready_mode = 0;
        build_expected(16'd10);
        start_pass(16'd10);
        wait_done(2000);
        repeat (3) @(negedge clk);
        tests++;
        if (got.size() != N) begin
            failures++; $display("[TB] FAIL tower_count: got %0d want %0d", got.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                tests++;
                if (got[i] !== exp_q[i] || got[i].idx !== 8'(i) || got[i].w !== 16'(256 - 4 * i)) begin
                    failures++; $display("[TB] FAIL tower_rec[%0d]: got %h want %h", i, got[i], exp_q[i]);
                end
            end
        end
        tests += 2;
        if (done_cyc != 577) begin failures++; $display("[TB] FAIL tower_done_cycle: got %0d want 577", done_cyc); end
        if (done_count != 1) begin failures++; $display("[TB] FAIL tower_done_count: got %0d want 1", done_count); end
    endtask

    task automatic test_miss();
        ready_mode = 0;
        start_pass(16'd300);
        wait_done(2000);
        repeat (3) @(negedge clk);
        tests += 6;
        if (valid_cycles != 0) begin failures++; $display("[TB] FAIL miss_valid: got %0d valid cycles want 0", valid_cycles); end
        if (done_cyc != 513) begin failures++; $display("[TB] FAIL miss_done_cycle: got %0d want 513", done_cyc); end
        if (done_count != 1) begin failures++; $display("[TB] FAIL miss_done_count: got %0d want 1", done_count); end
        if (first_busy != 1) begin failures++; $display("[TB] FAIL miss_busy_first: got %0d want 1", first_busy); end
        if (last_busy != 512) begin failures++; $display("[TB] FAIL miss_busy_last: got %0d want 512", last_busy); end
        if (busy_count != 512) begin failures++; $display("[TB] FAIL miss_busy_count: got %0d want 512", busy_count); end
    endtask

    task automatic test_backpressure();
        ready_mode = 2;
        stall_left = 5;
        build_expected(16'd10);
        start_pass(16'd10);
        wait_done(2000);
        repeat (3) @(negedge clk);
        tests++;
        if (got.size() != exp_q.size()) begin
            failures++; $display("[TB] FAIL bp_count: got %0d want %0d", got.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got.size(); i++) begin
                tests++;
                if (got[i] !== exp_q[i]) begin
                    failures++; $display("[TB] FAIL bp_rec[%0d]: got %h want %h", i, got[i], exp_q[i]);
                end
            end
        end
        tests += 3;
        if (done_cyc != 582) begin failures++; $display("[TB] FAIL bp_done_cycle: got %0d want 582", done_cyc); end
        if (stall_err != 0) begin failures++; $display("[TB] FAIL bp_stable: got %0d stall violations want 0", stall_err); end
        if (valid_cycles != 69) begin failures++; $display("[TB] FAIL bp_valid_cycles: got %0d want 69", valid_cycles); end
    endtask

    task automatic test_edge_filters();
        logic [15:0] cy[7], ch[7], cw[7], cl[7];
        bit          cen[7], chit[7];
        cen = '{0, 1, 1, 1, 1, 1, 1};
        cy  = '{16'd0, 16'd0, 16'd0, 16'hFFF0, 16'hFFF0, 16'd100, 16'd100};
        ch  = '{16'd10, 16'd0, 16'd10, 16'h0020, 16'h0020, 16'd7, 16'd7};
        cw  = '{16'd5, 16'd5, 16'd0, 16'd5, 16'd5, 16'd5, 16'd5};
        cl  = '{16'd3, 16'd0, 16'd3, 16'd5, 16'hFFF5, 16'd106, 16'd107};
        chit = '{0, 0, 0, 0, 1, 1, 0};
        ready_mode = 0;
        for (int j = 0; j < 7; j++) begin
            int k = $urandom_range(0, N - 1);
            int a = int'(BASE) + 6 * k;
            logic [15:0] xv = 16'($urandom);
            logic [15:0] cv = 16'($urandom);
            for (int i = 0; i < N; i++) begin
                mem[int'(BASE) + 6 * i] = {15'($urandom), 1'b0};
                for (int m = 1; m < 6; m++) mem[int'(BASE) + 6 * i + m] = 16'($urandom);
            end
            mem[a]     = {15'($urandom), cen[j]};
            mem[a + 1] = xv;
            mem[a + 2] = cy[j];
            mem[a + 3] = cw[j];
            mem[a + 4] = ch[j];
            mem[a + 5] = cv;
            start_pass(cl[j]);
            wait_done(2000);
            tests++;
            if (got.size() != (chit[j] ? 1 : 0)) begin
                failures++; $display("[TB] FAIL edge%0d_count: got %0d want %0d", j, got.size(), chit[j]);
            end else if (chit[j]) begin
                tests++;
                if (got[0] !== {8'(k), xv, cw[j], cv}) begin
                    failures++; $display("[TB] FAIL edge%0d_rec: got %h want %h", j, got[0], {8'(k), xv, cw[j], cv});
                end
            end
        end
    endtask

    task automatic test_control();
        bit seen = 0;
        load_tower();
        ready_mode = 0;
        build_expected(16'd10);
        start_pass(16'd10);
        repeat (100) @(negedge clk);
        line_y = 16'd300;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2000);
        // Re-pulse start during the done cycle itself
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        tests += 4;
        if (got.size() != exp_q.size() || (got.size() > 0 && got[got.size() - 1] !== exp_q[exp_q.size() - 1])) begin
            failures++; $display("[TB] FAIL ctl_stream: got %0d records want %0d", got.size(), exp_q.size());
        end
        if (done_cyc != 577) begin failures++; $display("[TB] FAIL ctl_done_cycle: got %0d want 577", done_cyc); end
        if (done_count != 1) begin failures++; $display("[TB] FAIL ctl_done_count: got %0d want 1", done_count); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ctl_done_restart: busy %b want 0", busy); end

        ready_mode = 3;
        start_pass(16'd10);
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            #2;
            if (rect_valid) seen = 1;
        end
        tests++;
        if (!seen) begin failures++; $display("[TB] FAIL ctl_emit_timeout: rect_valid %b want 1", rect_valid); end
        reset = 1'b1;
        @(negedge clk);
        #2;
        tests += 2;
        if (rect_valid !== 1'b0) begin failures++; $display("[TB] FAIL ctl_reset_valid: got %b want 0", rect_valid); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ctl_reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (done_count != 0) begin failures++; $display("[TB] FAIL ctl_reset_done: got %0d pulses want 0", done_count); end

        ready_mode = 1;
        start_pass(16'd10);
        wait_done(3000);
        tests += 3;
        if (got.size() != exp_q.size() || got != exp_q) begin
            failures++; $display("[TB] FAIL ctl_after_reset_stream: got %0d records want %0d", got.size(), exp_q.size());
        end
        if (done_cyc != 1 + 8 * N + valid_cycles) begin
            failures++; $display("[TB] FAIL ctl_after_reset_done: got %0d want %0d", done_cyc, 1 + 8 * N + valid_cycles);
        end
        if (stall_err != 0) begin failures++; $display("[TB] FAIL ctl_after_reset_stable: got %0d want 0", stall_err); end
    endtask

    task automatic test_random();
        ready_mode = 1;
        for (int it = 0; it < 4; it++) begin
            logic [15:0] ly = 16'($urandom_range(0, 70));
            for (int i = 0; i < N; i++) begin
                int a = int'(BASE) + 6 * i;
                mem[a]     = {15'($urandom), 1'($urandom)};
                mem[a + 1] = 16'($urandom);
                mem[a + 2] = 16'($urandom_range(0, 40));
                mem[a + 3] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
                mem[a + 4] = 16'($urandom_range(0, 30));
                mem[a + 5] = 16'($urandom);
            end
            build_expected(ly);
            start_pass(ly);
            wait_done(3000);
            tests++;
            if (got.size() != exp_q.size()) begin
                failures++; $display("[TB] FAIL rnd%0d_count: got %0d want %0d", it, got.size(), exp_q.size());
            end else begin
                for (int i = 0; i < got.size(); i++) begin
                    tests++;
                    if (got[i] !== exp_q[i]) begin
                        failures++; $display("[TB] FAIL rnd%0d_rec[%0d]: got %h want %h", it, i, got[i], exp_q[i]);
                    end
                end
            end
            tests += 2;
            if (done_cyc != 1 + 8 * N + valid_cycles) begin
                failures++; $display("[TB] FAIL rnd%0d_done_cycle: got %0d want %0d", it, done_cyc, 1 + 8 * N + valid_cycles);
            end
            if (stall_err != 0) begin failures++; $display("[TB] FAIL rnd%0d_stable: got %0d want 0", it, stall_err); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
        clear_mon();
        c0 = 0;
        test_reset();
        test_tower();
        test_miss();
        test_backpressure();
        test_edge_filters();
        test_control();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/gpu_rect_fetch.md
Name: gpu_rect_fetch

Overview:
- Downstream read-side client of the GPU rectangle memory. That memory is 1024x16, with a synchronous read port and 1-cycle read latency.
- On each `start` pulse, walks all rectangle records in index order and tests each against the scanline `line_y`.
- Streams every enabled rectangle that covers the line to the span rasterizer over a valid/ready handshake.
- Emission order is record index order, so the rasterizer can apply painter's priority: a later record wins.

Parameters:
- RECT_COUNT, 64: number of records scanned per pass (1..170).
- RECT_BASE, 16'd0: word address of record 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- line_y  in  16  scanline to test; latched when `start` is accepted.
- mem_addr  out  16  read address to the GPU memory read port.
- mem_rdata  in  16  read data; valid the cycle after `mem_addr`.
- rect_valid  out  1  rectangle record available.
- rect_ready  in  1  downstream accepts the record.
- rect_x  out  16  record word 1 (x).
- rect_w  out  16  record word 3 (width).
- rect_color  out  16  record word 5 (colour).
- rect_index  out  8  record number 0..RECT_COUNT-1.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at the end of a pass.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Record layout, 6 consecutive words per record: w0 enable (bit0 only), w1 x, w2 y, w3 width, w4 height, w5 colour.
- Reset values: all outputs 0. State IDLE; index, word counter and record pointer 0.
- Reset mid-pass: abort immediately to IDLE. No `done` pulse; `rect_valid` drops on the next edge.
- IDLE:
  - `start`=1 → latch `line_y`, ptr=RECT_BASE, index=0, word=0, go FETCH.
  - `busy`=1 from the next cycle until the cycle `done` is high (inclusive of neither start cycle nor post-done).
- FETCH, 6 cycles, word 0..5:
  - `mem_addr` = ptr+word, driven from registers.
  - In the cycle with word=k≥1, capture `mem_rdata` into record word k-1.
  - After word 5, go LAST.
- LAST, 1 cycle: capture word 5, go CHECK.
- CHECK, 1 cycle: hit = w0[0] & (w3≠0) & (w2 ≤ line_y) & (line_y < w2+w4).
  - The sum is computed at 17 bits, so there is no wrap-around.
  - hit → EMIT. Otherwise → NEXT logic.
- EMIT:
  - `rect_valid`=1; `rect_x`/`rect_w`/`rect_color`/`rect_index` are stable while `rect_valid` & !`rect_ready`.
  - Transfer occurs on a cycle with valid & ready → NEXT logic on that edge.
  - `rect_valid` never deasserts without a transfer, except on reset.
- NEXT logic, evaluated in the same edge:
  - If index = RECT_COUNT-1 → IDLE with `done`=1 in the following cycle.
  - Otherwise index+1, ptr+6 (adder only, no multiplier), word=0, back to FETCH.
- Per-record cost: 8 cycles if missed; 8 + EMIT cycles if hit (minimum 9).
- Pass timing, with `start` sampled in cycle 0: `done` is high in cycle 1 + 8·RECT_COUNT + total EMIT cycles.
- `start` asserted while busy, or in the `done` cycle, is ignored.
- `mem_addr` holds its last value in IDLE.

Test Plan:
- Reset: assert for 2 cycles → all outputs 0, `busy`=0; no `mem_addr` change until `start`.
- Tower image, `rect_ready`=1: memory preloaded with 64 records, rect i = {1, 0, 0, 256-4i, 256, colour_i}; `line_y`=10 → 64 transfers with indices 0..63 in order, widths 256, 252, …, 4, correct colours; `done` once at cycle 577.
- Miss pass: same image, `line_y`=300 → no `rect_valid`; `done` at cycle 513; `busy` high cycles 1..512.
- Backpressure: `line_y`=10, `rect_ready` low for 5 cycles during index 3 emission → `rect_x`/`rect_w`/`rect_color`/`rect_index` unchanged across the stall, no duplicate or lost record, `done` at cycle 582.
- Edge filters, on single-record passes:
  - enable=0 → no emit.
  - height=0 → no emit.
  - width=0 → no emit.
  - y=0xFFF0, h=0x20, `line_y`=5 → no emit.
  - y=0xFFF0, h=0x20, `line_y`=0xFFF5 → emit.
  - `line_y`=y+h-1 → emit; `line_y`=y+h → no emit.
- Control: `start` re-pulsed mid-pass → ignored, single `done`. Reset asserted during EMIT → `rect_valid`=0 and IDLE next cycle, no `done`; a new `start` then completes a normal pass.
